// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-stage ALU operand forward selects; EX/MEM takes priority over MEM/WB.
module fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  function automatic logic reg_match(input logic w, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] src);
    return w && (rd != '0) && (rd == src);
  endfunction

  function automatic logic [1:0] sel(input logic [REG_AW-1:0] src);
    if (reg_match(exmem_reg_write, exmem_rd, src))      return FWD_EXMEM;
    else if (reg_match(memwb_reg_write, memwb_rd, src)) return FWD_MEMWB;
    else                                                return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = sel(ex_rs);
    fwd_b = sel(ex_rt);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/bubble/flush control, forward selects, stall counter.
// Define FORWARD_EN to enable EX forwarding (hazards reduce to load-use only).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW       = REG_AW_DEF,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_reg_write,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_e             state_q, state_d;
  logic [2:0]         flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               hazard;
  logic [1:0]         fwd_a_raw, fwd_b_raw;

  function automatic logic reg_match(input logic w, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] src);
    return w && (rd != '0) && (rd == src);
  endfunction

`ifdef FORWARD_EN
  always_comb begin
    hazard = idex_mem_read &&
             (reg_match(idex_reg_write, idex_rd, id_rs) ||
              reg_match(idex_reg_write, idex_rd, id_rt));
  end

  fwd_unit #(
    .REG_AW (REG_AW)
  ) u_fwd (
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .fwd_a           (fwd_a_raw),
    .fwd_b           (fwd_b_raw)
  );
`else
  // Without forwarding, producers in EX or MEM must drain; WB is covered by write-before-read.
  always_comb begin
    hazard = reg_match(idex_reg_write,  idex_rd,  id_rs) ||
             reg_match(idex_reg_write,  idex_rd,  id_rt) ||
             reg_match(exmem_reg_write, exmem_rd, id_rs) ||
             reg_match(exmem_reg_write, exmem_rd, id_rt);
    fwd_a_raw = FWD_RF;
    fwd_b_raw = FWD_RF;
  end

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_rs, ex_rt, memwb_rd, memwb_reg_write, idex_mem_read};
`endif

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;

    if (branch_taken) begin
      state_d     = ST_FLUSH;
      flush_cnt_d = FLUSH_INIT;
    end else begin
      unique case (state_q)
        ST_RUN:   state_d = hazard ? ST_STALL : ST_RUN;
        ST_STALL: state_d = hazard ? ST_STALL : ST_RUN;
        ST_FLUSH: begin
          if (flush_cnt_q == '0) state_d = ST_RUN;
          else                   flush_cnt_d = flush_cnt_q - 3'd1;
        end
        default:  state_d = ST_RUN;
      endcase
    end

    if (branch_taken || state_q == ST_FLUSH) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_write && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (FLUSH_CYCLES=2, CNT_W=4).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, idex_rd, exmem_rd, memwb_rd;
  logic       idex_reg_write, idex_mem_read, exmem_reg_write, memwb_reg_write, branch_taken;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .REG_AW       (5),
    .FLUSH_CYCLES (2),
    .CNT_W        (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .idex_rd         (idex_rd),
    .idex_reg_write  (idex_reg_write),
    .idex_mem_read   (idex_mem_read),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .branch_taken    (branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0;
    idex_rd = '0; exmem_rd = '0; memwb_rd = '0;
    idex_reg_write = 1'b0; idex_mem_read = 1'b0;
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0; branch_taken = 1'b0;
  endtask

  // ctrl packs {pc_write, ifid_write, ifid_flush, idex_bubble}
  function automatic logic [7:0] ctrl();
    return {4'b0, pc_write, ifid_write, ifid_flush, idex_bubble};
  endfunction

  initial begin
    int unsigned cnt_exp;
    clear_inputs();
    reset = 1'b1;
    // load-use hazard present during reset must not be counted
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 5'd2; id_rs = 5'd2;
    exmem_rd = 5'd9; exmem_reg_write = 1'b1; ex_rs = 5'd9;
    #1;
    check("reset_ctrl", ctrl(), 8'b0011);
    check("reset_fwd_a", {6'b0, fwd_a}, 8'h0);
    tick(); tick();
    check("reset_cnt", {4'b0, stall_cnt}, 8'h0);
    reset = 1'b0;
    clear_inputs();
    #1;
    check("run_ctrl", ctrl(), 8'b1100);
    tick();

    // Test 1: load-use stalls exactly one cycle
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 5'd2; id_rs = 5'd2;
    #1;
    check("lu_ctrl", ctrl(), 8'b0001);
    tick();
    clear_inputs();
    #1;
    check("lu_after_ctrl", ctrl(), 8'b1100);
    check("lu_cnt", {4'b0, stall_cnt}, 8'h1);
    cnt_exp = 1;

    // register 0 never hazards
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 5'd0; id_rs = 5'd0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; ex_rs = 5'd0;
    #1;
    check("r0_ctrl", ctrl(), 8'b1100);
    check("r0_fwd_a", {6'b0, fwd_a}, 8'h0);
    tick();
    clear_inputs();

    // Test 2: forward select priority
    exmem_rd = 5'd3; exmem_reg_write = 1'b1; memwb_rd = 5'd3; memwb_reg_write = 1'b1;
    ex_rs = 5'd3; ex_rt = 5'd3;
    #1;
`ifdef FORWARD_EN
    check("fwd_a_exmem", {6'b0, fwd_a}, 8'h2);
    check("fwd_b_exmem", {6'b0, fwd_b}, 8'h2);
`else
    check("fwd_a_off", {6'b0, fwd_a}, 8'h0);
    check("fwd_b_off", {6'b0, fwd_b}, 8'h0);
`endif
    exmem_reg_write = 1'b0;
    #1;
`ifdef FORWARD_EN
    check("fwd_a_memwb", {6'b0, fwd_a}, 8'h1);
`else
    check("fwd_a_off2", {6'b0, fwd_a}, 8'h0);
`endif
    ex_rs = 5'd0;
    #1;
    check("fwd_a_rf", {6'b0, fwd_a}, 8'h0);
    tick();
    clear_inputs();

    // Test 3: dependent ALU op, producer walks EX -> MEM -> WB
    idex_rd = 5'd4; idex_reg_write = 1'b1; id_rt = 5'd4; ex_rt = 5'd4;
    #1;
`ifdef FORWARD_EN
    check("alu_s1_pc", {7'b0, pc_write}, 8'h1);
`else
    check("alu_s1_pc", {7'b0, pc_write}, 8'h0);
    cnt_exp++;
`endif
    check("alu_s1_fwd_b", {6'b0, fwd_b}, 8'h0);
    tick();
    idex_reg_write = 1'b0; exmem_rd = 5'd4; exmem_reg_write = 1'b1;
    #1;
`ifdef FORWARD_EN
    check("alu_s2_pc", {7'b0, pc_write}, 8'h1);
    check("alu_s2_fwd_b", {6'b0, fwd_b}, 8'h2);
`else
    check("alu_s2_pc", {7'b0, pc_write}, 8'h0);
    check("alu_s2_fwd_b", {6'b0, fwd_b}, 8'h0);
    cnt_exp++;
`endif
    tick();
    exmem_reg_write = 1'b0; memwb_rd = 5'd4; memwb_reg_write = 1'b1;
    #1;
    check("alu_s3_pc", {7'b0, pc_write}, 8'h1);
    check("alu_cnt", {4'b0, stall_cnt}, 8'(cnt_exp));
    tick();
    clear_inputs();

    // Test 4: branch overrides load-use, flush for branch cycle + 2
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 5'd5; id_rs = 5'd5;
    branch_taken = 1'b1;
    #1;
    check("br_c0_ctrl", ctrl(), 8'b1111);
    tick();
    branch_taken = 1'b0;
    #1;
    check("br_c1_ctrl", ctrl(), 8'b1111);
    tick();
    check("br_c2_ctrl", ctrl(), 8'b1111);
    tick();
    clear_inputs();
    #1;
    check("br_end_ctrl", ctrl(), 8'b1100);
    check("br_cnt", {4'b0, stall_cnt}, 8'(cnt_exp));
    tick();

    // Test 5: reset during STALL
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 5'd6; id_rt = 5'd6;
    #1;
    check("st_ctrl", ctrl(), 8'b0001);
    tick();
    check("st_hold_ctrl", ctrl(), 8'b0001);
    check("st_cnt", {4'b0, stall_cnt}, 8'(cnt_exp + 1));
    reset = 1'b1;
    #1;
    check("st_reset_ctrl", ctrl(), 8'b0011);
    tick();
    reset = 1'b0;
    clear_inputs();
    #1;
    check("st_post_ctrl", ctrl(), 8'b1100);
    check("st_post_cnt", {4'b0, stall_cnt}, 8'h0);
    tick();
    check("st_post_cnt2", {4'b0, stall_cnt}, 8'h0);

    // Test 6: counter saturates at 15
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 5'd7; id_rs = 5'd7;
    repeat (14) tick();
    check("sat_14", {4'b0, stall_cnt}, 8'd14);
    repeat (6) tick();
    check("sat_15", {4'b0, stall_cnt}, 8'd15);
    check("sat_pc", {7'b0, pc_write}, 8'h0);
    clear_inputs();
    tick();
    check("sat_hold", {4'b0, stall_cnt}, 8'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
